// File: rtl/lcd_text_refresh.sv
// lcd_text_refresh: reads a 2x16 character frame from the display-text RAM and
// keeps an HD44780-compatible character LCD refreshed after its power-up init.
// Build macro LCD_4BIT_EN selects 4-bit bus mode (nibble preamble, function set
// 0x28, every byte sent as high/low nibble on lcd_data[7:4]); default is 8-bit.
module lcd_text_refresh #(
    parameter int                    ADDR_WIDTH  = 9,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    POWERUP_CYC = 750000,
    parameter int                    E_CYC       = 25,
    parameter int                    CMD_CYC     = 2500,
    parameter int                    CLEAR_CYC   = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [7:0]            rdata,
    output logic                  lcd_rs,
    output logic                  lcd_rw,
    output logic                  lcd_e,
    output logic [7:0]            lcd_data,
    output logic                  init_done,
    output logic                  frame_done
);

    // One counter serves the power-up wait and the whole strobe+idle of a byte,
    // so it must hold the larger of the two without wrapping.
    localparam int WAIT_MAX   = (CLEAR_CYC > CMD_CYC) ? CLEAR_CYC : CMD_CYC;
    localparam int STROBE_MAX = E_CYC + WAIT_MAX + 2;
    localparam int CNT_MAX    = (POWERUP_CYC > STROBE_MAX) ? POWERUP_CYC : STROBE_MAX;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_CYC);
    localparam logic [CNT_W-1:0] CMD_STOP   = CNT_W'(E_CYC + CMD_CYC);
    localparam logic [CNT_W-1:0] CLEAR_STOP = CNT_W'(E_CYC + CLEAR_CYC);

    localparam logic [2:0] S_PWR_WAIT = 3'd0;
    localparam logic [2:0] S_INIT     = 3'd1;
    localparam logic [2:0] S_SET_ADDR = 3'd2;
    localparam logic [2:0] S_FETCH    = 3'd3;
    localparam logic [2:0] S_CHAR     = 3'd4;
    localparam logic [2:0] S_STROBE   = 3'd5;
    localparam logic [2:0] S_INIT_NXT = 3'd6;
    localparam logic [2:0] S_CHAR_NXT = 3'd7;

`ifdef LCD_4BIT_EN
    // Entries 0..3 are single-nibble wake-up writes (value in the high nibble).
    localparam logic [3:0]       INIT_LAST = 4'd9;
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(E_CYC + 2);

    function automatic logic [7:0] init_byte(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2: init_byte = 8'h30;
            4'd3:             init_byte = 8'h20;
            4'd4, 4'd5, 4'd6: init_byte = 8'h28;
            4'd7:             init_byte = 8'h0C;
            4'd8:             init_byte = 8'h01;
            4'd9:             init_byte = 8'h06;
            default:          init_byte = 8'h00;
        endcase
    endfunction
`else
    localparam logic [3:0] INIT_LAST = 4'd5;

    function automatic logic [7:0] init_byte(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2: init_byte = 8'h38;
            4'd3:             init_byte = 8'h0C;
            4'd4:             init_byte = 8'h01;
            4'd5:             init_byte = 8'h06;
            default:          init_byte = 8'h00;
        endcase
    endfunction
`endif

    logic [2:0]            state_r;
    logic [2:0]            ret_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      stop_r;
    logic [3:0]            init_idx_r;
    logic                  line_r;
    logic [3:0]            col_r;
    logic [7:0]            char_r;
    logic [ADDR_WIDTH-1:0] raddr_r;
    logic                  lcd_rs_r;
    logic                  lcd_e_r;
    logic [7:0]            lcd_data_r;
    logic                  init_done_r;
    logic                  frame_done_r;
`ifdef LCD_4BIT_EN
    logic [7:0]            byte_r;
    logic                  low_pend_r;
    logic                  load_single_s;
`endif

    logic [7:0]            load_byte_s;
    logic                  load_rs_s;
    logic                  load_clear_s;
    logic [2:0]            load_ret_s;
    logic [ADDR_WIDTH-1:0] fetch_addr_s;

    // Select the byte, register-select and follow-on state for the next bus write.
    always_comb begin
        load_byte_s   = 8'h00;
        load_rs_s     = 1'b0;
        load_clear_s  = 1'b0;
        load_ret_s    = S_FETCH;
`ifdef LCD_4BIT_EN
        load_single_s = 1'b0;
`endif
        case (state_r)
            S_INIT: begin
                load_byte_s   = init_byte(init_idx_r);
                load_clear_s  = (load_byte_s == 8'h01);
                load_ret_s    = S_INIT_NXT;
`ifdef LCD_4BIT_EN
                load_single_s = (init_idx_r < 4'd4);
`endif
            end
            S_SET_ADDR: begin
                load_byte_s = line_r ? 8'hC0 : 8'h80;
                load_ret_s  = S_FETCH;
            end
            S_CHAR: begin
                load_byte_s = (char_r == 8'h00) ? 8'h20 : char_r;
                load_rs_s   = 1'b1;
                load_ret_s  = S_CHAR_NXT;
            end
            default: begin
                load_byte_s = 8'h00;
            end
        endcase
    end

    // Frame position to RAM address; wraps naturally at ADDR_WIDTH bits.
    always_comb begin
        fetch_addr_s = BASE_ADDR + ADDR_WIDTH'({line_r, col_r});
    end

    // Main sequencer: power-up wait, init table, address commands, character refresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= S_PWR_WAIT;
            ret_r        <= S_FETCH;
            cnt_r        <= '0;
            stop_r       <= '0;
            init_idx_r   <= 4'd0;
            line_r       <= 1'b0;
            col_r        <= 4'd0;
            char_r       <= 8'h00;
            raddr_r      <= BASE_ADDR;
            lcd_rs_r     <= 1'b0;
            lcd_e_r      <= 1'b0;
            lcd_data_r   <= 8'h00;
            init_done_r  <= 1'b0;
            frame_done_r <= 1'b0;
`ifdef LCD_4BIT_EN
            byte_r       <= 8'h00;
            low_pend_r   <= 1'b0;
`endif
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                S_PWR_WAIT: begin
                    if (cnt_r == PWR_LAST) begin
                        cnt_r      <= '0;
                        init_idx_r <= 4'd0;
                        state_r    <= S_INIT;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                // This edge is the setup cycle: rs/data driven, lcd_e still low.
                S_INIT, S_SET_ADDR, S_CHAR: begin
                    lcd_rs_r <= load_rs_s;
`ifdef LCD_4BIT_EN
                    lcd_data_r <= {load_byte_s[7:4], 4'b0000};
                    byte_r     <= load_byte_s;
                    low_pend_r <= !load_single_s;
`else
                    lcd_data_r <= load_byte_s;
`endif
                    stop_r  <= load_clear_s ? CLEAR_STOP : CMD_STOP;
                    ret_r   <= load_ret_s;
                    cnt_r   <= '0;
                    state_r <= S_STROBE;
                    if (state_r == S_SET_ADDR) begin
                        col_r <= 4'd0;
                    end
                end
                // E high for E_CYC clocks, one hold clock, then the idle wait.
                S_STROBE: begin
                    cnt_r   <= cnt_r + 1'b1;
                    lcd_e_r <= (cnt_r < E_LAST);
`ifdef LCD_4BIT_EN
                    if (low_pend_r && (cnt_r == LOW_LOAD)) begin
                        lcd_data_r <= {byte_r[3:0], 4'b0000};
                        low_pend_r <= 1'b0;
                        cnt_r      <= '0;
                    end else if (!low_pend_r && (cnt_r == stop_r)) begin
                        state_r <= ret_r;
                        cnt_r   <= '0;
                    end
`else
                    if (cnt_r == stop_r) begin
                        state_r <= ret_r;
                        cnt_r   <= '0;
                    end
`endif
                end
                // Drive the address, then latch RAM dout two edges later.
                S_FETCH: begin
                    cnt_r <= cnt_r + 1'b1;
                    if (cnt_r == '0) begin
                        raddr_r <= fetch_addr_s;
                    end
                    if (cnt_r == CNT_W'(2)) begin
                        char_r  <= rdata;
                        cnt_r   <= '0;
                        state_r <= S_CHAR;
                    end
                end
                S_INIT_NXT: begin
                    if (init_idx_r == INIT_LAST) begin
                        init_done_r <= 1'b1;
                        line_r      <= 1'b0;
                        state_r     <= S_SET_ADDR;
                    end else begin
                        init_idx_r <= init_idx_r + 4'd1;
                        state_r    <= S_INIT;
                    end
                end
                S_CHAR_NXT: begin
                    cnt_r <= '0;
                    if (col_r == 4'd15) begin
                        col_r   <= 4'd0;
                        state_r <= S_SET_ADDR;
                        if (line_r) begin
                            frame_done_r <= 1'b1;
                            line_r       <= 1'b0;
                        end else begin
                            line_r <= 1'b1;
                        end
                    end else begin
                        col_r   <= col_r + 4'd1;
                        state_r <= S_FETCH;
                    end
                end
                default: begin
                    state_r <= S_PWR_WAIT;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign raddr      = raddr_r;
    assign lcd_rs     = lcd_rs_r;
    assign lcd_rw     = 1'b0;
    assign lcd_e      = lcd_e_r;
    assign lcd_data   = lcd_data_r;
    assign init_done  = init_done_r;
    assign frame_done = frame_done_r;

endmodule

// File: doc/lcd_text_refresh.md
Name: lcd_text_refresh

Overview:
Downstream consumer of the 512x8 display-text RAM.
- Continuously reads a 2x16 character frame from the RAM read port and drives an HD44780-compatible character LCD over its 8-bit parallel bus.
- Performs the LCD power-up initialisation sequence, then refreshes both display lines forever.
- Shares the RAM read clock with the RAM, so frame contents written by the temperature formatter appear on the LCD within one refresh period.

Parameters:
ADDR_WIDTH, 9, RAM address width; must match the RAM.
BASE_ADDR, 9'h000, RAM address of line-1 column-0; line 2 starts at BASE_ADDR+16.
POWERUP_CYC, 750000, clocks to wait after reset before the first command (15 ms at 50 MHz).
E_CYC, 25, clocks lcd_e is held high per byte (min 450 ns).
CMD_CYC, 2500, clocks idle after each byte before the next one (>=40 us).
CLEAR_CYC, 100000, clocks idle after the clear-display command (>=1.64 ms).

Ports:
clk  in  1  single clock; also drives the RAM rclk
reset  in  1  asynchronous active-low reset
raddr  out  ADDR_WIDTH  RAM read address
rdata  in  8  RAM dout; registered, valid on the 2nd clk edge after raddr is driven
lcd_rs  out  1  0 = command, 1 = character data
lcd_rw  out  1  tied 0 (write only)
lcd_e  out  1  LCD enable strobe
lcd_data  out  8  LCD data bus
init_done  out  1  high once the init table has completed; stays high until reset
frame_done  out  1  one-clk pulse after the 32nd character of each frame

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0; raddr=BASE_ADDR.
  - Cycle counter cleared; state = PWR_WAIT.
  - Reset asserted mid-strobe drops lcd_e immediately. Release always restarts the full power-up and init sequence.
- States: PWR_WAIT -> INIT -> SET_ADDR -> FETCH -> CHAR -> (CHAR-loop) -> SET_ADDR ...
- PWR_WAIT: count POWERUP_CYC clocks, then enter INIT with init index 0.
- INIT: issue the fixed table as commands (rs=0): 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
  - Entry 0x01 is followed by CLEAR_CYC idle; all others by CMD_CYC idle.
  - After entry 5, set init_done=1 and go to SET_ADDR with line=0.
- Byte-write timing (common to commands and characters):
  - Cycle 0: lcd_rs and lcd_data are driven; lcd_e=0 (setup cycle).
  - Cycles 1..E_CYC: lcd_e=1.
  - Then lcd_e=0 with rs and data held stable for 1 further clock (hold), followed by the idle wait.
  - lcd_data and lcd_rs change only while lcd_e=0.
- SET_ADDR: command 0x80 for line 0, 0xC0 for line 1; column counter reset to 0.
- FETCH:
  - raddr = BASE_ADDR + 16*line + col, with ADDR_WIDTH-bit wrap-around.
  - Wait 2 clocks for the registered RAM output, then latch rdata into an internal char register.
- CHAR:
  - Write the latched byte with rs=1. Byte 0x00 is substituted by 0x20 (space); all other values, including 0xDF, pass unchanged.
  - After the idle wait: col++. If col==16, advance to the next line.
  - Leaving line 1 pulses frame_done for 1 clk, sets line=0 and returns to SET_ADDR. Otherwise continue to FETCH.
- The frame loop never terminates. RAM writes during a frame are visible at the next fetch of that address; no tearing protection.
- Counters are sized to hold max(POWERUP_CYC, CLEAR_CYC) and must not wrap early.

Optional Feature:
Macro LCD_4BIT_EN.
- Defined: 4-bit bus mode.
  - Only lcd_data[7:4] is used; lcd_data[3:0] is held 0.
  - Before the init table, send the single nibble 0x3 three times (CMD_CYC apart), then nibble 0x2.
  - Function set becomes 0x28 instead of 0x38.
  - Every byte is sent high nibble then low nibble. Each nibble gets its own setup/E_CYC/hold strobe, with 1 clk between the two nibbles; the idle wait follows the low nibble only.
- Undefined: 8-bit mode exactly as described under Behaviour.

Test Plan:
1. Reset release with POWERUP_CYC=100, E_CYC=2, CMD_CYC=10, CLEAR_CYC=50 -> first lcd_e rise at cycle 102 with lcd_data=0x38, rs=0; the six init bytes follow in table order; idle after 0x01 >= 50 clks; init_done=1 after 0x06.
2. RAM preloaded with "Tysia:* 00:00:00" / "+000,0000" + 0xDF + "C" plus spaces -> the bus shows 0x80, then 16 rs=1 bytes matching line 1; then 0xC0, then line 2 including 0xDF; frame_done pulses once.
3. RAM byte at BASE_ADDR+3 = 0x00 -> the 4th character written is 0x20.
4. BASE_ADDR=9'h1F8 -> raddr sequence 0x1F8..0x1FF, then 0x000..0x017 (wrap).
5. Reset pulled low while lcd_e=1 during a CHAR write -> lcd_e=0 in the same cycle; after release no strobe occurs before POWERUP_CYC and init restarts at 0x38.
6. With LCD_4BIT_EN, character 0x54 -> two strobes with lcd_data[7:4]=0x5 then 0x4, rs=1, lcd_data[3:0]=0 throughout.
